// File: rtl/dds_pkg.sv
// Shared definitions for the DDS register-map Wishbone initiator: FSM encoding,
// register addresses and the default ack timeout.
package dds_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_GAP    = 2'd2,
        ST_RESP   = 2'd3
    } wb_state_t;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 16;

    localparam logic [15:0] REG_READY  = 16'd0;
    localparam logic [15:0] REG_ENABLE = 16'd1;
    localparam logic [15:0] REG_SRC    = 16'd2;
    localparam logic [15:0] REG_TUNING = 16'd3;
    localparam logic [15:0] REG_GAIN   = 16'd4;
    localparam logic [15:0] REG_OFFSET = 16'd5;

endpackage

// File: rtl/dds_wb_initiator.sv
// Turns one host command into one classic single-beat Wishbone cycle and returns
// the read data (or a timeout flag) on a held response port.
module dds_wb_initiator
    import dds_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_n_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [DATA_WIDTH-1:0] cmd_dat_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_dat_o,
    output logic                  rsp_err_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [ADDR_WIDTH-1:0] wb_addr_o,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    input  logic                  wb_ack_i
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    wb_state_t             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  cmd_ready_d;
    logic                  rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_dat_d;
    logic                  rsp_err_d;
    logic                  stb_d;
    logic                  we_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] wdat_d;

    // State and every output are flops; reset drops stb and discards any pending response.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cmd_ready_o <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_dat_o   <= '0;
            rsp_err_o   <= 1'b0;
            wb_stb_o    <= 1'b0;
            wb_we_o     <= 1'b0;
            wb_addr_o   <= '0;
            wb_dat_o    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_ready_o <= cmd_ready_d;
            rsp_valid_o <= rsp_valid_d;
            rsp_dat_o   <= rsp_dat_d;
            rsp_err_o   <= rsp_err_d;
            wb_stb_o    <= stb_d;
            wb_we_o     <= we_d;
            wb_addr_o   <= addr_d;
            wb_dat_o    <= wdat_d;
        end
    end

    // Next-state and next-output logic; wb_ack_i only matters while strobing.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_o;
        rsp_dat_d   = rsp_dat_o;
        rsp_err_d   = rsp_err_o;
        stb_d       = wb_stb_o;
        we_d        = wb_we_o;
        addr_d      = wb_addr_o;
        wdat_d      = wb_dat_o;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i && cmd_ready_o) begin
                    stb_d   = 1'b1;
                    we_d    = cmd_we_i;
                    addr_d  = cmd_addr_i;
                    wdat_d  = cmd_dat_i;
                    cnt_d   = '0;
                    state_d = ST_STROBE;
                end
            end
            ST_STROBE: begin
                // An ack on the threshold cycle still completes the transfer cleanly.
                if (wb_ack_i) begin
                    stb_d     = 1'b0;
                    rsp_dat_d = wb_we_o ? '0 : wb_dat_i;
                    rsp_err_d = 1'b0;
                    state_d   = ST_GAP;
                end else if (cnt_q >= CNT_LAST) begin
                    stb_d     = 1'b0;
                    rsp_dat_d = '0;
                    rsp_err_d = 1'b1;
                    state_d   = ST_GAP;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                // Absorbs the stale registered ack the slave may still return.
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
    end

endmodule

// File: tb/tb_dds_wb_initiator.sv
// Bench for dds_wb_initiator: a programmable-latency register slave plus a
// transaction-level reference model of registers, timeouts and response timing.
module tb_dds_wb_initiator;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 16;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_we = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_dat = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_dat;
    logic          rsp_err;
    logic          wb_stb;
    logic          wb_we;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_wdat;
    logic [DW-1:0] wb_rdat;
    logic          wb_ack;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dds_wb_initiator #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_we_i   (cmd_we),
        .cmd_addr_i (cmd_addr),
        .cmd_dat_i  (cmd_dat),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_dat_o  (rsp_dat),
        .rsp_err_o  (rsp_err),
        .wb_stb_o   (wb_stb),
        .wb_we_o    (wb_we),
        .wb_addr_o  (wb_addr),
        .wb_dat_o   (wb_wdat),
        .wb_dat_i   (wb_rdat),
        .wb_ack_i   (wb_ack)
    );

    // Slave: registered ack after ack_lat extra stb cycles; ack follows stb so it can go stale.
    logic [DW-1:0] sregs [0:7];
    int            ack_lat = 0;
    bit            ack_never = 1'b0;
    int            wcnt;

    function automatic logic [DW-1:0] reset_val(input int i);
        if (i == 0) return 32'h0000_0001;
        if (i == 5) return 32'h0000_00FF;
        return 32'h0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_ack  <= 1'b0;
            wb_rdat <= '0;
            wcnt    <= 0;
            for (int i = 0; i < 8; i++) sregs[i] <= reset_val(i);
        end else if (wb_stb && !ack_never) begin
            if (wcnt >= ack_lat) begin
                wb_ack <= 1'b1;
                if (wb_we) sregs[wb_addr[2:0]] <= wb_wdat;
                else       wb_rdat <= sregs[wb_addr[2:0]];
            end else begin
                wb_ack <= 1'b0;
            end
            wcnt <= wcnt + 1;
        end else begin
            wb_ack <= 1'b0;
            wcnt   <= 0;
        end
    end

    // Reference register image, maintained from commands alone.
    logic [DW-1:0] ref_regs [0:7];

    task automatic ref_reset();
        for (int i = 0; i < 8; i++) ref_regs[i] = reset_val(i);
    endtask

    // Drives one command, measures stb cycles and response latency, then consumes the response after hold cycles.
    task automatic run_cmd(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] dat,
                           input int lat, input bit never, input int hold,
                           output logic [DW-1:0] got_dat, output logic got_err,
                           output int stb_cnt, output int rsp_lat, output bit stable);
        int guard;
        ack_lat   = lat;
        ack_never = never;
        stb_cnt   = 0;
        rsp_lat   = -1;
        stable    = 1'b1;
        guard     = 0;
        @(negedge clk);
        while (!cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_dat   = dat;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (wb_stb) stb_cnt++;
            if (rsp_valid) begin
                rsp_lat = j;
                break;
            end
        end
        got_dat = rsp_dat;
        got_err = rsp_err;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_dat !== got_dat || rsp_err !== got_err || cmd_ready !== 1'b0)
                stable = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    // Full check of one transaction against the reference model.
    task automatic check_txn(input string name, input logic we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] dat, input int lat, input bit never, input int hold);
        logic [DW-1:0] got_dat, exp_dat;
        logic          got_err;
        int            stb_cnt, rsp_lat, exp_stb;
        bit            stable, tmo;
        tmo     = never || (lat > TO - 2);
        exp_stb = tmo ? TO : lat + 2;
        exp_dat = (tmo || we) ? '0 : ref_regs[addr[2:0]];
        run_cmd(we, addr, dat, lat, never, hold, got_dat, got_err, stb_cnt, rsp_lat, stable);
        // Slave commits once it has seen stb on lat+1 edges, even if the initiator already gave up.
        if (we && !never && (lat + 1 <= exp_stb)) ref_regs[addr[2:0]] = dat;
        n_vec++;
        if (got_dat !== exp_dat) begin
            n_err++;
            $display("FAIL %s rsp_dat got=%h exp=%h", name, got_dat, exp_dat);
        end
        n_vec++;
        if (got_err !== tmo) begin
            n_err++;
            $display("FAIL %s rsp_err got=%b exp=%b", name, got_err, tmo);
        end
        n_vec++;
        if (stb_cnt != exp_stb) begin
            n_err++;
            $display("FAIL %s stb_cycles got=%0d exp=%0d", name, stb_cnt, exp_stb);
        end
        n_vec++;
        if (rsp_lat != exp_stb + 1) begin
            n_err++;
            $display("FAIL %s rsp_latency got=%0d exp=%0d", name, rsp_lat, exp_stb + 1);
        end
        if (hold > 0) begin
            n_vec++;
            if (!stable) begin
                n_err++;
                $display("FAIL %s rsp_hold_stable got=0 exp=1", name);
            end
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        ref_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (cmd_ready !== 1'b0 || wb_stb !== 1'b0 || rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl got=%b%b%b exp=000", cmd_ready, wb_stb, rsp_valid);
        end
        n_vec++;
        if ({rsp_dat, rsp_err, wb_we, wb_addr, wb_wdat} !== '0) begin
            n_err++;
            $display("FAIL reset_data got=%h/%b/%b/%h/%h exp=0", rsp_dat, rsp_err, wb_we, wb_addr, wb_wdat);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (cmd_ready !== 1'b1 || wb_stb !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release ready/stb got=%b/%b exp=1/0", cmd_ready, wb_stb);
        end
    endtask

    task automatic test_read_default();
        check_txn("read_offset", 1'b0, dds_pkg::REG_OFFSET, 32'h0, 0, 1'b0, 0);
        n_vec++;
        if (ref_regs[5] !== 32'h0000_00FF) begin
            n_err++;
            $display("FAIL offset_reset_model got=%h exp=000000ff", ref_regs[5]);
        end
    endtask

    task automatic test_write();
        check_txn("write_tuning", 1'b1, dds_pkg::REG_TUNING, 32'h0000_0010, 0, 1'b0, 0);
        check_txn("readback_tuning", 1'b0, dds_pkg::REG_TUNING, 32'h0, 0, 1'b0, 0);
    endtask

    task automatic test_timeout();
        check_txn("no_ack", 1'b0, dds_pkg::REG_GAIN, 32'h0, 0, 1'b1, 0);
        check_txn("ack_at_threshold", 1'b0, dds_pkg::REG_OFFSET, 32'h0, TO - 2, 1'b0, 0);
        check_txn("ack_after_threshold", 1'b1, dds_pkg::REG_GAIN, $urandom, TO - 1, 1'b0, 0);
        check_txn("late_write_readback", 1'b0, dds_pkg::REG_GAIN, 32'h0, 1, 1'b0, 0);
    endtask

    task automatic test_hold();
        check_txn("hold_rsp", 1'b0, dds_pkg::REG_TUNING, 32'h0, 0, 1'b0, 10);
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] wd, rd8;
        int  acc [0:1];
        int  n_acc;
        bit  rdy_prev;
        bit  stb_tr [0:11];
        bit  rv_tr  [0:11];
        int  guard;
        wd        = $urandom;
        ack_lat   = 0;
        ack_never = 1'b0;
        n_acc     = 0;
        acc[0]    = -1;
        acc[1]    = -1;
        rd8       = '0;
        guard     = 0;
        rsp_ready = 1'b1;
        @(negedge clk);
        while (!cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_addr  = dds_pkg::REG_SRC;
        cmd_dat   = wd;
        rdy_prev  = cmd_ready;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (rdy_prev && cmd_valid) begin
                acc[n_acc] = c;
                n_acc++;
                if (n_acc == 1) begin
                    cmd_we = 1'b0;
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            @(negedge clk);
            stb_tr[c] = wb_stb;
            rv_tr[c]  = rsp_valid;
            rdy_prev  = cmd_ready;
            if (c == 8) rd8 = rsp_dat;
        end
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        ref_regs[2] = wd;
        n_vec++;
        if (acc[0] != 0 || acc[1] != 5) begin
            n_err++;
            $display("FAIL b2b_accept_cycles got=%0d,%0d exp=0,5", acc[0], acc[1]);
        end
        for (int c = 0; c < 12; c++) begin
            n_vec++;
            if (stb_tr[c] != (c == 0 || c == 1 || c == 5 || c == 6)) begin
                n_err++;
                $display("FAIL b2b_stb[%0d] got=%b exp=%b", c, stb_tr[c], !stb_tr[c]);
            end
            n_vec++;
            if (rv_tr[c] != (c == 3 || c == 8)) begin
                n_err++;
                $display("FAIL b2b_rsp_valid[%0d] got=%b exp=%b", c, rv_tr[c], !rv_tr[c]);
            end
        end
        n_vec++;
        if (rd8 !== wd) begin
            n_err++;
            $display("FAIL b2b_read_data got=%h exp=%h", rd8, wd);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        int guard;
        ack_never = 1'b1;
        guard     = 0;
        @(negedge clk);
        while (!cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_addr  = dds_pkg::REG_ENABLE;
        cmd_dat   = $urandom;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (wb_stb !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_async stb/rv/rdy got=%b/%b/%b exp=0/0/0", wb_stb, rsp_valid, cmd_ready);
        end
        ref_reset();
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid || wb_stb) seen = 1'b1;
        end
        n_vec++;
        if (seen) begin
            n_err++;
            $display("FAIL mid_reset_no_rsp got=1 exp=0");
        end
        check_txn("post_reset_read", 1'b0, dds_pkg::REG_OFFSET, 32'h0, 0, 1'b0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            check_txn($sformatf("rand%0d", i), 1'($urandom_range(0, 1)),
                      AW'($urandom_range(0, 5)), $urandom,
                      int'($urandom_range(0, 16)), ($urandom_range(0, 7) == 0),
                      int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        test_reset();
        test_read_default();
        test_write();
        test_timeout();
        test_hold();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
